// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch-stage control, instruction-memory and IF/ID signal bundle
// Optional feature macro: IF_MISALIGN_EN adds id_misalign to the bundle.
interface if_fetch_stage_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
`ifdef IF_MISALIGN_EN
  logic        id_misalign;

  // Fetch stage view: it masters the instruction-memory bus and drives IF/ID.
  modport master (
    input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, id_valid, id_pc, id_pc4, id_inst, id_misalign
  );

  // Environment view: memory, hazard unit, next-PC block and decode.
  modport slave (
    output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, id_valid, id_pc, id_pc4, id_inst, id_misalign
  );
`else
  // Fetch stage view: it masters the instruction-memory bus and drives IF/ID.
  modport master (
    input  redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, id_valid, id_pc, id_pc4, id_inst
  );

  // Environment view: memory, hazard unit, next-PC block and decode.
  modport slave (
    output redirect, redirect_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, id_valid, id_pc, id_pc4, id_inst
  );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC register, single-outstanding imem fetch, IF/ID register
// Optional feature macro: IF_MISALIGN_EN (misaligned redirect traps into IF/ID instead of fetching).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_stage_if.master bus
);

`ifdef IF_MISALIGN_EN
  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_TRAP = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc4;
  logic [31:0] r_hold_inst;
  logic [31:0] w_redirect_pc;
  logic        w_deliver;
  logic [31:0] w_deliver_inst;
  logic        w_capture;
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic [31:0] r_id_inst;
`ifdef IF_MISALIGN_EN
  logic        w_misalign_tgt;
  logic        w_trap_load;
  logic        r_trap_done;
  logic        r_id_misalign;
`endif

  // Sequential PC; wraps modulo 2^32 naturally.
  assign w_pc4 = r_pc + 32'd4;

`ifdef IF_MISALIGN_EN
  // Misaligned targets are kept as-is so the trap can report the exact PC.
  assign w_redirect_pc  = bus.redirect_pc;
  assign w_misalign_tgt = (bus.redirect_pc[1:0] != 2'b00);
`else
  // Without trap support the low bits are meaningless and are cleared.
  assign w_redirect_pc = bus.redirect_pc & ~32'd3;
`endif

  assign bus.imem_req  = (r_state == S_REQ) && !rst;
  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = r_id_valid;
  assign bus.id_pc     = r_id_pc;
  assign bus.id_pc4    = r_id_pc4;
  assign bus.id_inst   = r_id_inst;
`ifdef IF_MISALIGN_EN
  assign bus.id_misalign = r_id_misalign;
`endif

  // Next-state and per-cycle actions; redirect outranks every other event.
  always_comb begin
    w_state_nxt    = r_state;
    w_deliver      = 1'b0;
    w_deliver_inst = r_hold_inst;
    w_capture      = 1'b0;
`ifdef IF_MISALIGN_EN
    w_trap_load    = 1'b0;
`endif
    if (bus.redirect) begin
`ifdef IF_MISALIGN_EN
      if (w_misalign_tgt) begin
        // No fetch is issued for a misaligned target; any response in flight is ignored.
        w_state_nxt = S_TRAP;
      end else
`endif
      begin
        case (r_state)
          // A granted request carries the old address: its response must be dropped.
          S_REQ:   w_state_nxt = bus.imem_gnt ? S_DROP : S_REQ;
          S_WAIT:  w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
          S_DROP:  w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
          default: w_state_nxt = S_REQ;
        endcase
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (bus.imem_gnt) begin
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (bus.stall) begin
              w_capture   = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_deliver      = 1'b1;
              w_deliver_inst = bus.imem_rdata;
              w_state_nxt    = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            w_deliver      = 1'b1;
            w_deliver_inst = r_hold_inst;
            w_state_nxt    = S_REQ;
          end
        end
        S_DROP: begin
          if (bus.imem_rvalid) begin
            w_state_nxt = S_REQ;
          end
        end
`ifdef IF_MISALIGN_EN
        S_TRAP: begin
          // The trap marker enters IF/ID once; fetch then idles until redirected.
          if (!bus.stall && !r_trap_done) begin
            w_trap_load = 1'b1;
          end
        end
`endif
        default: w_state_nxt = S_REQ;
      endcase
    end
  end

  // State, PC and stalled-response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_hold_inst <= NOP_INST;
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_deliver) begin
        r_pc <= w_pc4;
      end
      if (w_capture) begin
        r_hold_inst <= bus.imem_rdata;
      end
    end
  end

  // IF/ID register: redirect flushes, delivery loads, stall holds, otherwise bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'd0;
      r_id_pc4   <= 32'd4;
      r_id_inst  <= NOP_INST;
    end else if (bus.redirect) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end else if (w_deliver) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc4;
      r_id_inst  <= w_deliver_inst;
`ifdef IF_MISALIGN_EN
    end else if (w_trap_load) begin
      r_id_valid <= 1'b1;
      r_id_pc    <= r_pc;
      r_id_pc4   <= w_pc4;
      r_id_inst  <= NOP_INST;
`endif
    end else if (!bus.stall) begin
      r_id_valid <= 1'b0;
      r_id_inst  <= NOP_INST;
    end
  end

`ifdef IF_MISALIGN_EN
  // Misalign flag follows IF/ID: set only by the trap load, cleared by any other load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_misalign <= 1'b0;
      r_trap_done   <= 1'b0;
    end else if (bus.redirect) begin
      r_id_misalign <= 1'b0;
      r_trap_done   <= 1'b0;
    end else if (w_deliver) begin
      r_id_misalign <= 1'b0;
    end else if (w_trap_load) begin
      r_id_misalign <= 1'b1;
      r_trap_done   <= 1'b1;
    end else if (!bus.stall) begin
      r_id_misalign <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage (optional macro IF_MISALIGN_EN)
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  if_fetch_stage_if bus();

  if_fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    if (a == 32'd8) return 32'h00A0_0113;
    return {a[23:0], 8'h13};
  endfunction

  // Memory remembers the address of the accepted request and answers with its word.
  logic [31:0] mem_addr = 32'd0;
  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_gnt) mem_addr <= bus.imem_addr;
  end
  assign bus.imem_rdata = inst_at(mem_addr);

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: outstanding request, dropped response, stalled data, IF/ID content.
  logic        m_init = 1'b0;
  logic        m_req, m_out, m_dead, m_held, m_trap, m_trap_pend, d_go;
  logic [31:0] m_pc, m_out_addr, m_held_data, d_pc, d_inst;
  logic        e_valid, e_mis;
  logic [31:0] e_pc, e_pc4, e_inst;

  initial begin
    forever begin
      @(negedge clk);
      m_req = !rst && !m_out && !m_dead && !m_held && !m_trap;
      if (m_init) begin
        chk1 ("imem_req",  bus.imem_req,  m_req);
        chk32("imem_addr", bus.imem_addr, m_pc);
        chk1 ("id_valid",  bus.id_valid,  e_valid);
        chk32("id_pc",     bus.id_pc,     e_pc);
        chk32("id_pc4",    bus.id_pc4,    e_pc4);
        chk32("id_inst",   bus.id_inst,   e_inst);
`ifdef IF_MISALIGN_EN
        chk1 ("id_misalign", bus.id_misalign, e_mis);
`endif
      end
      if (rst) begin
        m_init = 1'b1;
        m_pc = 32'd0; m_out = 1'b0; m_dead = 1'b0; m_held = 1'b0;
        m_trap = 1'b0; m_trap_pend = 1'b0; m_out_addr = 32'd0; m_held_data = 32'd0;
        e_valid = 1'b0; e_pc = 32'd0; e_pc4 = 32'd4; e_inst = NOP; e_mis = 1'b0;
      end else if (m_init) begin
        d_go = 1'b0; d_pc = 32'd0; d_inst = NOP;
        if ((m_out || m_dead) && bus.imem_rvalid) begin
          if (m_out && !bus.redirect) begin
            if (bus.stall) begin
              m_held = 1'b1; m_held_data = inst_at(m_out_addr);
            end else begin
              d_go = 1'b1; d_pc = m_out_addr; d_inst = inst_at(m_out_addr);
            end
          end
          m_out = 1'b0; m_dead = 1'b0;
        end else if (m_held && !bus.stall && !bus.redirect) begin
          d_go = 1'b1; d_pc = m_pc; d_inst = m_held_data; m_held = 1'b0;
        end
        if (m_req && bus.imem_gnt) begin
          m_out = 1'b1; m_out_addr = m_pc;
        end
        if (bus.redirect) begin
          if (m_out) begin m_out = 1'b0; m_dead = 1'b1; end
          m_held = 1'b0; m_trap = 1'b0; m_trap_pend = 1'b0;
`ifdef IF_MISALIGN_EN
          m_pc = bus.redirect_pc;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            m_trap = 1'b1; m_trap_pend = 1'b1; m_out = 1'b0; m_dead = 1'b0;
          end
`else
          m_pc = {bus.redirect_pc[31:2], 2'b00};
`endif
          e_valid = 1'b0; e_inst = NOP; e_mis = 1'b0;
        end else if (d_go) begin
          e_valid = 1'b1; e_pc = d_pc; e_pc4 = d_pc + 32'd4; e_inst = d_inst; e_mis = 1'b0;
          m_pc = d_pc + 32'd4;
        end else if (m_trap_pend && !bus.stall) begin
          e_valid = 1'b1; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_inst = NOP; e_mis = 1'b1;
          m_trap_pend = 1'b0;
        end else if (!bus.stall) begin
          e_valid = 1'b0; e_inst = NOP; e_mis = 1'b0;
        end
      end
    end
  end

  // One cycle of directed stimulus: redirect, target, stall, gnt, rvalid.
  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic st,
                     input logic g, input logic rv);
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.stall       = st;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = 32'd0; bus.stall = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk1 ("rst req",      bus.imem_req,  1'b0);
    chk1 ("rst valid",    bus.id_valid,  1'b0);
    chk32("rst id_pc",    bus.id_pc,     32'd0);
    chk32("rst id_pc4",   bus.id_pc4,    32'd4);
    chk32("rst id_inst",  bus.id_inst,   NOP);
    chk32("rst addr",     bus.imem_addr, 32'd0);

    rst = 1'b0;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk1 ("first valid",  bus.id_valid,  1'b1);
    chk32("first pc",     bus.id_pc,     32'd0);
    chk32("first inst",   bus.id_inst,   32'h0050_0093);
    chk32("first next",   bus.imem_addr, 32'd4);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk32("pc4 inst",     bus.id_inst,   32'h0000_0413);

    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk32("stall pc",     bus.id_pc,     32'd4);
    chk32("stall inst",   bus.id_inst,   32'h0000_0413);
    chk1 ("stall req",    bus.imem_req,  1'b0);
    cyc(0, 0, 0, 0, 0);
    chk32("unstall pc",   bus.id_pc,     32'd8);
    chk32("unstall inst", bus.id_inst,   32'h00A0_0113);
    chk32("unstall next", bus.imem_addr, 32'd12);

    cyc(0, 0, 0, 1, 0);
    chk1 ("bubble valid", bus.id_valid,  1'b0);
    chk32("bubble pc",    bus.id_pc,     32'd8);
    cyc(1, 32'h100, 0, 0, 0);
    chk1 ("drop req",     bus.imem_req,  1'b0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk1 ("late valid",   bus.id_valid,  1'b0);
    chk32("late inst",    bus.id_inst,   NOP);
    chk32("late next",    bus.imem_addr, 32'h100);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk32("tgt inst",     bus.id_inst,   32'h0001_0013);

    cyc(1, 32'h10, 0, 0, 0);
    cyc(1, 32'h200, 0, 1, 0);
    chk1 ("gntrd req",    bus.imem_req,  1'b0);
    cyc(0, 0, 0, 0, 1);
    chk1 ("gntrd valid",  bus.id_valid,  1'b0);
    chk32("gntrd next",   bus.imem_addr, 32'h200);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk32("200 inst",     bus.id_inst,   32'h0002_0013);

`ifdef IF_MISALIGN_EN
    cyc(1, 32'h102, 0, 0, 0);
    chk1 ("trap req",     bus.imem_req,  1'b0);
    cyc(0, 0, 1, 0, 0);
    chk1 ("trap stalled", bus.id_valid,  1'b0);
    cyc(0, 0, 0, 0, 0);
    chk1 ("trap valid",   bus.id_valid,  1'b1);
    chk32("trap pc",      bus.id_pc,     32'h102);
    chk1 ("trap flag",    bus.id_misalign, 1'b1);
    chk1 ("trap idle",    bus.imem_req,  1'b0);
    cyc(1, 32'h200, 0, 0, 0);
    chk32("resume addr",  bus.imem_addr, 32'h200);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk1 ("resume flag",  bus.id_misalign, 1'b0);
    chk32("resume pc",    bus.id_pc,     32'h200);
`else
    cyc(1, 32'h102, 0, 0, 0);
    chk32("align addr",   bus.imem_addr, 32'h100);
`endif

    cyc(1, 32'hFFFF_FFFC, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk32("wrap pc",      bus.id_pc,     32'hFFFF_FFFC);
    chk32("wrap pc4",     bus.id_pc4,    32'd0);
    chk32("wrap next",    bus.imem_addr, 32'd0);

    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(1, 32'h40, 1, 0, 0);
    chk1 ("holdrd valid", bus.id_valid,  1'b0);
    chk32("holdrd addr",  bus.imem_addr, 32'h40);
    cyc(0, 0, 0, 0, 1);
    chk1 ("stray req",    bus.imem_req,  1'b1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h80, 0, 0, 1);
    chk1 ("wrv req",      bus.imem_req,  1'b1);
    cyc(1, 32'hC0, 0, 1, 0);
    cyc(1, 32'hE0, 0, 0, 0);
    chk32("dbl addr",     bus.imem_addr, 32'hE0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk32("dbl pc",       bus.id_pc,     32'hE0);

    cyc(0, 0, 0, 1, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk1 ("mid rst valid", bus.id_valid, 1'b0);
    chk32("mid rst addr", bus.imem_addr, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
    end
    chk32("b2b pc",       bus.id_pc,     32'd8);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
